// File: rtl/apb3_master_bridge_pkg.sv
// Shared types and helpers for the APB3 master bridge.
package apb3_master_bridge_pkg;

    // Bridge FSM states; the 2-bit encoding is fixed so that debug views match.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Bits needed to hold values 0..n, with a minimum of one bit.
    function automatic int counter_width(input int n);
        int w;
        for (w = 1; (w < 31) && ((1 << w) < (n + 1)); w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/apb3_master_bridge_if.sv
// Command/response channel plus APB3 bus seen by the bridge.
interface apb3_master_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERROR;

    // Bridge side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PREADY, PRDATA, PSLVERROR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    // User logic plus APB slave side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PREADY, PRDATA, PSLVERROR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb3_timeout_counter.sv
// Counts ACCESS cycles spent waiting for PREADY; flags the last allowed one.
module apb3_timeout_counter
    import apb3_master_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = counter_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise increment and saturate instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != SAT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = (count_q == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: single-word commands in, SETUP/ACCESS transfers out,
// held response with slave error and PREADY timeout reporting.
module apb3_master_bridge
    import apb3_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    apb3_master_bridge_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  busy_q, busy_d;

    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  cnt_expired;

    apb3_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Only ACCESS cycles without PREADY advance the timeout.
    assign cnt_enable = (state_q == ACCESS) && !bus.PREADY;

    // Transfer sequencing and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d  = bus.cmd_write;
                    // Word-aligned: the byte-lane bits are dropped.
                    paddr_d   = bus.cmd_addr & WORD_MASK;
                    if (bus.cmd_write) begin
                        pwdata_d = bus.cmd_wdata;
                    end
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A slave completing on the last allowed cycle beats the timeout.
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_error_d   = bus.PSLVERROR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (cnt_expired) begin
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Randomized bench for the APB3 master bridge with a transaction-level model.
module tb_apb3_master_bridge;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   txn_no;
    logic [DW-1:0] last_wdata;

    apb3_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb3_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command from acceptance to consumed response. waits = ACCESS cycles the
    // slave holds PREADY low before asserting it; hold = cycles rsp_ready stays low.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input logic serr, input logic [DW-1:0] srdata,
                           input int hold);
        logic [DW-1:0] exp_rdata;
        logic [AW-1:0] exp_addr;
        logic          exp_err;
        logic          exp_to;
        int            exp_access;
        int            lat;
        int            acc;

        // Reference: outcome of the transfer from the protocol rules.
        exp_addr = addr & 12'hFFC;
        if (waits >= TMO) begin
            exp_to = 1'b1; exp_err = 1'b1; exp_rdata = '0; exp_access = TMO;
        end else begin
            exp_to = 1'b0; exp_err = serr; exp_rdata = wr ? '0 : srdata; exp_access = waits + 1;
        end
        if (wr) last_wdata = wdata;

        check("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge clk);
        lat = 1;
        // Scramble the command bus to prove values were latched.
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = $urandom;
        check("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
        check("setup_paddr", bus.PADDR, exp_addr);
        check("setup_pwrite", bus.PWRITE, wr);
        check("setup_pwdata", bus.PWDATA, last_wdata);
        check("setup_busy", bus.busy, 1);

        acc = 0;
        while (!bus.rsp_valid && lat < 40) begin
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                check("access_stable", {bus.PADDR, bus.PWRITE, bus.PWDATA}, {exp_addr, wr, last_wdata});
                bus.PREADY    = (acc > waits);
                bus.PRDATA    = bus.PREADY ? srdata : DW'($urandom);
                bus.PSLVERROR = bus.PREADY ? serr : 1'($urandom);
            end else begin
                // PREADY outside ACCESS must be ignored.
                bus.PREADY    = 1'($urandom);
                bus.PRDATA    = $urandom;
                bus.PSLVERROR = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.PREADY    = 1'b0;
        bus.PSLVERROR = 1'b0;

        check("latency", lat, 2 + exp_access);
        check("access_cycles", acc, exp_access);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_error", bus.rsp_error, exp_err);
        check("rsp_timeout", bus.rsp_timeout, exp_to);
        check("resp_bus_idle", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.busy}, 4'b0001);

        // Back-pressure with a new command pending.
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_hold", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout,
                              bus.cmd_ready, bus.PSEL}, {1'b1, exp_rdata, exp_err, exp_to, 2'b00});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rsp_consumed", {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.PSEL}, 4'b0100);

        $display("[TB] txn %0d wr=%0d addr=%h waits=%0d hold=%0d -> rdata=%h err=%0d to=%0d",
                 txn_no, wr, addr, waits, hold, bus.rsp_rdata, exp_err, exp_to);
        txn_no++;
    endtask

    initial begin
        logic [AW-1:0] a;
        int            w;
        tests_run     = 0;
        tests_failed  = 0;
        txn_no        = 0;
        last_wdata    = '0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERROR = 1'b0;

        #3;
        check("reset_outputs", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid,
                                bus.rsp_error, bus.rsp_timeout, bus.busy}, 7'd0);
        check("reset_data", {bus.PADDR, bus.PWDATA, bus.rsp_rdata}, 76'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {bus.cmd_ready, bus.busy, bus.rsp_valid}, 3'b100);

        // Directed cases
        run_txn(1'b1, 12'h004, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 12'h00B, 32'h0, 3, 1'b0, 32'h12345678, 0);
        run_txn(1'b0, 12'h120, 32'h0, 0, 1'b1, 32'hA5A5F00F, 1);
        run_txn(1'b0, 12'h3F1, 32'h0, 100, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 12'h3F1, 32'h0, TMO - 1, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b1, 12'h7FE, 32'h01234567, 2, 1'b1, 32'h0, 10);
        run_txn(1'b1, 12'h010, 32'h89ABCDEF, 100, 1'b0, 32'h0, 2);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO, TMO + 4)) : int'($urandom_range(0, TMO - 1));
            a = AW'($urandom);
            run_txn(1'($urandom), a, $urandom, w, 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        // Reset during a wait-stated ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h044;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("async_reset_drop", {bus.PSEL, bus.PENABLE, bus.busy, bus.rsp_valid}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", {bus.rsp_valid, bus.cmd_ready, bus.PSEL}, 3'b010);
        end
        last_wdata = '0;
        run_txn(1'b0, 12'h048, 32'h0, 1, 1'b0, 32'h55AA55AA, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
APB3 initiator that converts single-word user commands (valid/ready) into compliant APB3 SETUP/ACCESS transfers toward on-chip APB3 slave register blocks. It returns read data and error status on a held response channel. A per-transfer PREADY timeout keeps a hung slave from locking the bus. It sits between user/test logic and APB3 peripherals, or is used as a bench-side driver for slave blocks.

Parameters:
ADDR_WIDTH, 12, width of cmd_addr and PADDR
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  byte address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available, held until rsp_ready
rsp_ready  input  1  response consumed
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_error  output  1  PSLVERROR sampled, or timeout
rsp_timeout  output  1  transfer aborted by timeout
busy  output  1  state != IDLE
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  slave ready
PRDATA  input  DATA_WIDTH  slave read data
PSLVERROR  input  1  slave error

Behaviour:
- Reset (async, immediate): state IDLE. PSEL, PENABLE, PWRITE, rsp_valid, rsp_error, rsp_timeout, busy = 0. PADDR, PWDATA, rsp_rdata = 0. Timeout counter = 0. cmd_ready = 1 once reset deasserts.
- All APB outputs and rsp_* are registered; none is combinationally derived from inputs. cmd_ready = (state == IDLE).
- States: IDLE=0, SETUP=1, ACCESS=2, RESP=3.
- IDLE: on cmd_valid & cmd_ready, latch cmd_write into PWRITE, {cmd_addr[ADDR_WIDTH-1:2], 2'b00} into PADDR (word-aligned; low bits discarded), and cmd_wdata into PWDATA (writes only; PWDATA unchanged on reads). Next state SETUP with PSEL=1, PENABLE=0.
- SETUP: exactly one cycle, then ACCESS with PENABLE=1. PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS.
- ACCESS: PREADY is sampled every cycle.
  - If PREADY = 1: rsp_rdata <= PWRITE ? 0 : PRDATA; rsp_error <= PSLVERROR; rsp_timeout <= 0. Drop PSEL and PENABLE. Go to RESP.
  - Else, with TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: abort with rsp_error=1, rsp_timeout=1, rsp_rdata=0. Drop PSEL and PENABLE. Go to RESP.
  - Else counter increments.
  - PREADY=1 on the final timeout cycle counts as a normal completion; it wins over the timeout.
  - The counter clears on entry to SETUP.
- RESP: rsp_valid=1 and rsp_* stay stable. On rsp_ready, go to IDLE and set rsp_valid=0. cmd_ready stays 0 for the whole RESP state, so commands back up behind an unconsumed response.
- Latency: zero-wait-state transfer takes accept edge → SETUP → ACCESS → RESP, so rsp_valid rises 3 cycles after acceptance. Peak throughput is one transfer per 4 cycles with rsp_ready held high.
- PADDR, PWRITE and PWDATA hold their last values in IDLE and RESP; they are not cleared.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, any pending response is lost, and no response is generated for the aborted command.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It saturates; it never wraps.

Decomposition:
- Shared package/include: state localparams (IDLE, SETUP, ACCESS, RESP; 2-bit encoding) and a clog2 function for the counter width.
- One sub-module is natural: apb3_timeout_counter. Inputs: clear, enable. Output: expired. Parameter: TIMEOUT_CYCLES; when 0, expired is tied to 0.

Test Plan:
- Write: cmd write addr 0x004, data 0xDEADBEEF, slave PREADY=1 in the first ACCESS cycle → PSEL up 1 cycle before PENABLE, PADDR=0x004, PWDATA=0xDEADBEEF. Then rsp_valid, rsp_error=0, rsp_rdata=0 three cycles after acceptance.
- Read with wait states: cmd read addr 0x00B, slave holds PREADY=0 for 3 ACCESS cycles then returns 0x12345678 → PADDR=0x008, PENABLE high for 4 cycles, rsp_rdata=0x12345678.
- Slave error: read with PREADY=1 and PSLVERROR=1 → rsp_error=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, PREADY never asserted → exactly 8 ACCESS cycles, then rsp_error=1, rsp_timeout=1, rsp_rdata=0. A repeat run with PREADY rising on the 8th ACCESS cycle gives a normal completion.
- Back-pressure: rsp_ready=0 for 10 cycles with cmd_valid held → cmd_ready=0 and no new PSEL. After rsp_ready=1, the next command is accepted the following cycle.
- Reset mid-ACCESS: assert reset during a wait-stated ACCESS → PSEL/PENABLE=0 in the same cycle, and no rsp_valid after release.
